// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg -- shared definitions for the mem_responder slice.
//
// Holds the FSM state encoding, the default geometry/latency constants,
// the width of the word index carried by a byte address, and the access
// legality helper used by the responder.
//
// No ports (package).

package mem_resp_pkg;

  // Defaults for the responder parameters.
  localparam int unsigned DEF_DEPTH   = 32'd64;
  localparam int unsigned DEF_LATENCY = 32'd2;

  // A byte address carries its word index in bits [31:2].
  localparam int unsigned WORD_IDX_W  = 32'd30;

  // Wait counter width; holds LATENCY-1 for the legal range 1..15.
  localparam int unsigned LAT_CNT_W   = 32'd4;

  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is legal when it is word aligned and its word index is
  // inside the array.
  function automatic logic access_ok(input logic [31:0] adr,
                                     input logic [31:0] depth);
    logic [31:0] widx;
    widx = {2'b00, adr[31:2]};
    return (adr[1:0] == 2'b00) && (widx < depth);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram -- DEPTH x 32 storage array for mem_responder.
//
// Synchronous write, combinational read. Contents are never reset, so the
// array keeps its data across a responder reset.
//
// Ports:
//   clk    in   clock; write happens on the rising edge
//   we     in   write enable
//   waddr  in   word index to write (AW bits)
//   wdata  in   32-bit write data
//   raddr  in   word index to read (AW bits)
//   rdata  out  32-bit read data, combinational from raddr

module mem_resp_ram #(
  parameter int unsigned DEPTH = 32'd64,
  parameter int unsigned AW    = 32'd6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Synchronous write port; no reset on the storage itself.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- single-outstanding memory responder with fixed latency.
//
// An initiator raises req with memwrite/dataadr/writedata. While IDLE the
// request is latched, the responder waits LATENCY cycles (WAIT) and then
// spends one cycle in RESP with ready high. ready, err and the load result
// in readdata are all valid together during that RESP cycle. A store is
// committed to the array on the edge that leaves RESP, so a reset that
// lands during WAIT or RESP aborts the access without touching memory.
//
// Misaligned or out-of-range accesses complete with err=1, readdata=0 and
// no write. readdata holds its value across stores.
//
// Optional feature, macro MEM_RESP_MATCH_EN: when defined, match is a sticky
// flag set by a committed store of MATCH_DATA to MATCH_ADDR and cleared only
// by reset. When undefined, match is constant 0 and no compare is built.
//
// Parameters:
//   DEPTH       number of 32-bit words (default 64)
//   LATENCY     wait cycles before the response, legal 1..15 (default 2)
//   MATCH_ADDR  byte address watched by the store-match flag (default 84)
//   MATCH_DATA  data value watched by the store-match flag (default 7)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req        in   request valid (ignored unless IDLE)
//   memwrite   in   1 = store, 0 = load
//   dataadr    in   32-bit byte address
//   writedata  in   32-bit store data
//   readdata   out  32-bit load result
//   ready      out  one-cycle completion pulse
//   busy       out  high while a request is outstanding
//   err        out  error qualifier, valid with ready
//   match      out  sticky store-match flag

module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned LATENCY    = DEF_LATENCY,
  parameter int unsigned MATCH_ADDR = 32'd84,
  parameter int unsigned MATCH_DATA = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic        match
);

  // Word index width needed to address DEPTH entries.
  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  // The counter starts at LATENCY-1 and RESP is entered on the cycle it
  // reads 0, giving LATENCY cycles of WAIT.
  localparam lat_cnt_t CNT_INIT = LAT_CNT_W'(LATENCY - 32'd1);

  state_t        state_r;
  lat_cnt_t      cnt_r;
  logic          we_r;
  logic [31:0]   adr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   readdata_r;
  logic          ready_r;
  logic          busy_r;
  logic          err_r;

  logic          acc_ok_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   rdata_s;
  logic          commit_s;

  assign acc_ok_s = access_ok(adr_r, 32'(DEPTH));
  assign widx_s   = adr_r[AW+1:2];

  // Stores commit on the edge leaving RESP; an async reset in RESP moves
  // the FSM to IDLE first, so the write is dropped.
  assign commit_s = (state_r == RESP) && we_r && acc_ok_s;

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (commit_s),
    .waddr (widx_s),
    .wdata (wdata_r),
    .raddr (widx_s),
    .rdata (rdata_s)
  );

  // Responder FSM with all handshake outputs and the load result registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      we_r       <= 1'b0;
      adr_r      <= 32'd0;
      wdata_r    <= 32'd0;
      readdata_r <= 32'd0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          if (req) begin
            we_r    <= memwrite;
            adr_r   <= dataadr;
            wdata_r <= writedata;
            cnt_r   <= CNT_INIT;
            busy_r  <= 1'b1;
            state_r <= WAIT;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        WAIT: begin
          if (cnt_r == '0) begin
            // Entering RESP: present ready, err and any load data together.
            state_r <= RESP;
            ready_r <= 1'b1;
            err_r   <= !acc_ok_s;
            if (!acc_ok_s) begin
              readdata_r <= 32'd0;
            end else if (!we_r) begin
              readdata_r <= rdata_s;
            end else begin
              readdata_r <= readdata_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end

        RESP: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign readdata = readdata_r;
  assign ready    = ready_r;
  assign busy     = busy_r;
  assign err      = err_r;

`ifdef MEM_RESP_MATCH_EN
  logic match_r;

  // Sticky flag: set by a committed store of the watched value to the
  // watched address; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_r <= 1'b0;
    end else if (commit_s && (adr_r == 32'(MATCH_ADDR))
                 && (wdata_r == 32'(MATCH_DATA))) begin
      match_r <= 1'b1;
    end else begin
      match_r <= match_r;
    end
  end

  assign match = match_r;
`else
  // Constant 0; the watch parameters appear only so this build still
  // references them. No comparator exists here.
  assign match = 1'b0 & (|{32'(MATCH_ADDR), 32'(MATCH_DATA)});
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed bench for mem_responder with an
// in-bench transaction-level model and per-cycle output comparison.

`timescale 1ns/1ps

module tb_mem_responder;

  localparam int unsigned L     = 2;
  localparam int unsigned DEPTH = 64;

`ifdef MEM_RESP_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, req15 = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0, writedata = 32'd0;

  logic [31:0] readdata0, readdata1, readdata15;
  logic        ready0, busy0, err0, match0;
  logic        ready1, busy1, err1, match1;
  logic        ready15, busy15, err15, match15;

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(L), .MATCH_ADDR(84), .MATCH_DATA(7)) dut (
    .clk(clk), .reset(reset), .req(req0), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata0), .ready(ready0), .busy(busy0),
    .err(err0), .match(match0));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .MATCH_ADDR(84), .MATCH_DATA(7)) u_l1 (
    .clk(clk), .reset(reset), .req(req1), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata1), .ready(ready1), .busy(busy1),
    .err(err1), .match(match1));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(15), .MATCH_ADDR(84), .MATCH_DATA(7)) u_l15 (
    .clk(clk), .reset(reset), .req(req15), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata15), .ready(ready15), .busy(busy15),
    .err(err15), .match(match15));

  always #5 clk = ~clk;

  // ---------------- transaction model for the LATENCY=2 instance ----------
  // An accepted request is tracked by its age in clock edges: the response
  // window is age L, the store lands when age reaches L+1.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_active = 1'b0;
  int          m_age = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_adr = 32'd0, m_wd = 32'd0;
  logic [31:0] m_rd = 32'd0;
  bit          m_rd_known = 1'b1;
  bit          m_match = 1'b0;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  // Model update on each clock edge, cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active   <= 1'b0;
      m_age      <= 0;
      m_rd       <= 32'd0;
      m_rd_known <= 1'b1;
      m_match    <= 1'b0;
    end else if (m_active) begin
      m_age <= m_age + 1;
      if (m_age + 1 == L) begin
        if (!legal(m_adr)) begin
          m_rd       <= 32'd0;
          m_rd_known <= 1'b1;
        end else if (!m_we) begin
          m_rd       <= m_mem[m_adr[7:2]];
          m_rd_known <= m_known[m_adr[7:2]];
        end
      end
      if (m_age == L) begin
        if (m_we && legal(m_adr)) begin
          m_mem[m_adr[7:2]]   <= m_wd;
          m_known[m_adr[7:2]] <= 1'b1;
          if (m_adr == 32'd84 && m_wd == 32'd7) m_match <= 1'b1;
        end
        m_active <= 1'b0;
      end
    end else if (req0) begin
      m_active <= 1'b1;
      m_age    <= 0;
      m_we     <= memwrite;
      m_adr    <= dataadr;
      m_wd     <= writedata;
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    bit e_ready, e_err, e_match;
    e_ready = m_active && (m_age == L);
    e_err   = e_ready && !legal(m_adr);
    e_match = MATCH_ON && m_match;
    n_vec++;
    if (ready0 !== e_ready || busy0 !== m_active || err0 !== e_err ||
        match0 !== e_match || (m_rd_known && readdata0 !== m_rd)) begin
      n_err++;
      $display("FAIL cycle t=%0t: ready/busy/err/match/readdata got %b/%b/%b/%b/%h, required %b/%b/%b/%b/%h",
               $time, ready0, busy0, err0, match0, readdata0,
               e_ready, m_active, e_err, e_match, m_rd);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
    bit seen;
    seen = 1'b0; rd = 32'd0; er = 1'b0; lat = 0;
    @(negedge clk);
    req0 = 1'b1; memwrite = w; dataadr = a; writedata = d;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (ready0) begin
        seen = 1'b1; lat = i; rd = readdata0; er = err0;
      end
    end
    req0 = 1'b0;
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL op_timeout: no ready for addr %h, required one within 40 cycles", a);
    end
  endtask

  task automatic sweep(input int sel, output int lat, output int nbusy, output int nready);
    bit seen;
    logic rdy, bsy;
    seen = 1'b0; lat = 0; nbusy = 0; nready = 0;
    @(negedge clk);
    memwrite = 1'b0; dataadr = 32'd4;
    if (sel == 1) req1 = 1'b1; else req15 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rdy = (sel == 1) ? ready1 : ready15;
      bsy = (sel == 1) ? busy1 : busy15;
      if (bsy) nbusy++;
      if (rdy) nready++;
      if (rdy && !seen) begin
        seen = 1'b1; lat = i; req1 = 1'b0; req15 = 1'b0;
      end
    end
    req1 = 1'b0; req15 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nb, nr, pulses;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, ready0}, 32'd0);
    check("reset_readdata", readdata0, 32'd0);
    #2 reset = 1'b1;

    // Stores that must not trip the match flag.
    do_op(1'b1, 32'd80, 32'd7, rd, er, lat);
    do_op(1'b1, 32'd84, 32'd8, rd, er, lat);
    @(negedge clk);
    check("match_near_miss", {31'd0, match0}, 32'd0);

    // Preload a few words.
    do_op(1'b1, 32'd40, 32'h1111_2222, rd, er, lat);
    do_op(1'b1, 32'd88, 32'hA5A5_0088, rd, er, lat);
    do_op(1'b1, 32'd0,  32'hC0DE_0000, rd, er, lat);

    // Store then load at the watched address.
    do_op(1'b1, 32'd84, 32'h0000_0007, rd, er, lat);
    check("store84_latency", lat, 32'd3);
    check("store84_err", {31'd0, er}, 32'd0);
    @(negedge clk);
    check("match_set", {31'd0, match0}, {31'd0, MATCH_ON});
    do_op(1'b0, 32'd84, 32'd0, rd, er, lat);
    check("load84_latency", lat, 32'd3);
    check("load84_err", {31'd0, er}, 32'd0);
    check("load84_data", rd, 32'h0000_0007);

    // Error cases.
    do_op(1'b0, 32'h0000_0082, 32'd0, rd, er, lat);
    check("misaligned_err", {31'd0, er}, 32'd1);
    check("misaligned_data", rd, 32'd0);
    do_op(1'b1, 32'd256, 32'h0000_0055, rd, er, lat);
    check("range_err", {31'd0, er}, 32'd1);
    do_op(1'b0, 32'd0, 32'd0, rd, er, lat);
    check("load0_after_bad_store", rd, 32'hC0DE_0000);
    check("load0_err", {31'd0, er}, 32'd0);

    // req held high with a new address while busy: only one access.
    @(negedge clk);
    req0 = 1'b1; memwrite = 1'b0; dataadr = 32'd84;
    @(negedge clk);
    memwrite = 1'b1; dataadr = 32'd88; writedata = 32'h0BAD_F00D;
    pulses = 0; rd = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready0) begin
        pulses++; rd = readdata0; req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    check("busy_ignore_pulses", pulses, 32'd1);
    check("busy_ignore_data", rd, 32'h0000_0007);
    do_op(1'b0, 32'd88, 32'd0, rd, er, lat);
    check("addr88_untouched", rd, 32'hA5A5_0088);
    check("match_sticky", {31'd0, match0}, {31'd0, MATCH_ON});

    // Reset during WAIT aborts a store.
    @(negedge clk);
    req0 = 1'b1; memwrite = 1'b1; dataadr = 32'd40; writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    #2 reset = 1'b0; req0 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready0) pulses++;
    end
    check("reset_abort_pulses", pulses, 32'd0);
    check("reset_clears_match", {31'd0, match0}, 32'd0);
    #2 reset = 1'b1;
    do_op(1'b0, 32'd40, 32'd0, rd, er, lat);
    check("load40_prior", rd, 32'h1111_2222);

    // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
    sweep(1, lat, nb, nr);
    check("l1_ready_cycle", lat, 32'd2);
    check("l1_busy_cycles", nb, 32'd2);
    check("l1_ready_pulses", nr, 32'd1);
    sweep(15, lat, nb, nr);
    check("l15_ready_cycle", lat, 32'd16);
    check("l15_busy_cycles", nb, 32'd16);
    check("l15_ready_pulses", nr, 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
